sram_rw_requester: RTL and testbench
====================================

# sram_rw_requester

Initiator-side controller for a single-port, one-cycle-latency synchronous RW SRAM macro (the `*_ext` RW0 macro shape: addr/en/wmode/byte-wmask/wdata in, rdata out). It turns a valid/ready request stream into legal RW0-port cycles and returns read data on a valid/ready response stream. A small response FIFO absorbs response backpressure. After reset it zero-fills the array before accepting traffic.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width; depth is 2^ADDR_W.
- `DATA_W`, 32, SRAM word width.
- `MASK_W`, 4, write-mask width, one bit per DATA_W/MASK_W-bit lane.
- `RESP_DEPTH`, 3, response FIFO entries; minimum 2, and 3 gives full read throughput.
- `INIT_ON_RESET`, 1, when 1, zero-fill the whole array after reset.

Ports:
- `clock` in 1: sole clock; also drives the SRAM `RW0_clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W / `req_wmask` in MASK_W: write payload.
- `resp_valid` out 1 / `resp_ready` in 1 / `resp_rdata` out DATA_W: read response.
- `init_done` out 1: high once the zero-fill has finished, or immediately after BOOT when INIT_ON_RESET=0.
- `sram_en`, `sram_wmode` out 1; `sram_addr` out ADDR_W; `sram_wmask` out MASK_W; `sram_wdata` out DATA_W: these drive the RW0 port.
- `sram_rdata` in DATA_W: RW0 read data, valid in the cycle after a read.

## Operation
- FSM states BOOT → INIT → RUN. BOOT is the reset state.
  - BOOT lasts one cycle and issues no SRAM access.
  - BOOT goes to INIT, or to RUN when INIT_ON_RESET=0.
- INIT:
  - `sram_en`=1, `sram_wmode`=1, `sram_wmask`=all ones, `sram_wdata`=0.
  - `sram_addr` = init counter, starting at 0 and incrementing each cycle.
  - After the cycle that writes address 2^ADDR_W−1, go to RUN.
  - `req_ready`=0 throughout INIT.
- RUN:
  - `req_ready` = (fifo_count + rd_pending < RESP_DEPTH). It does not depend on `req_valid`, `req_write` or `resp_ready`.
  - On a request handshake: `sram_en`=1 and `sram_wmode`=`req_write`; addr/wdata/wmask pass straight through combinationally. Otherwise `sram_en`=0.
  - An accepted read sets `rd_pending` for the next cycle. In that cycle `sram_rdata` is pushed into the FIFO.
  - Writes produce no response.
- The FIFO pops on `resp_valid && resp_ready`. Push and pop in the same cycle leave the count unchanged.
- A FIFO overflow is impossible by construction. Verification asserts it never occurs.
- Outputs in RUN with no handshake: `sram_wmode`=0, `sram_wmask`=0, `sram_wdata`=0, `sram_addr`=0.

## Timing
- Reset values:
  - state=BOOT; `req_ready`=0, `resp_valid`=0, `init_done`=0, `sram_en`=0.
  - Init counter=0, FIFO empty, `rd_pending`=0.
- `reset_n` asserted at any point, including mid-INIT or with responses queued:
  - Everything clears immediately; queued and pending responses are discarded.
  - The sequence restarts at BOOT and the zero-fill restarts from address 0.
- Init length: BOOT is cycle 0, INIT covers cycles 1…2^ADDR_W, and `init_done` and `req_ready` rise in cycle 2^ADDR_W+1 (cycle 1025 at defaults).
- Read latency: a read accepted in cycle N has rdata captured at the end of N+1. `resp_valid` is high from cycle N+2.
- Throughput: with RESP_DEPTH≥3 and `resp_ready` held at 1, one read is accepted per cycle. With RESP_DEPTH=2 this drops to 2 reads per 3 cycles.
- Write accepted in cycle N followed by a read of the same address in cycle N+1: the read returns the newly written data.
- `resp_rdata` is held stable while `resp_valid && !resp_ready`.

## Structure
- Package `sram_requester_pkg`:
  - state enum `req_state_e` with values BOOT, INIT, RUN.
  - default-width localparams.
- Sub-module `sram_resp_fifo`: synchronous FIFO of depth RESP_DEPTH and width DATA_W, with a count output and the same async active-low reset.
- The top level holds the FSM, init counter, `rd_pending` and port muxing.

## Test plan
- Zero-fill: ADDR_W=4, model preloaded with random data; release reset. Expect 16 writes of 0 to addresses 0..15 in cycles 1..16, `init_done` rising in cycle 17, and a read of address 7 returning 0.
- Masked write: write 0xAABBCCDD to address 3 with mask 0xF, then 0x11223344 with mask 0x5, then read address 3. Expect 0xAA22CC44.
- Backpressure: 5 back-to-back reads with `resp_ready`=0. Expect exactly 3 accepted, then `req_ready`=0. Raising `resp_ready` drains the responses in order and accepts the remaining reads.
- Throughput: 8 reads of addresses 0..7 with `resp_ready`=1. Expect `req_ready` continuously 1 and responses on 8 consecutive cycles starting 2 cycles after the first accept.
- Reset mid-operation: assert `reset_n` low during INIT at address 9, and again with 2 responses queued. Expect `resp_valid` to fall immediately and INIT to restart at address 0.
- Write-then-read hazard: write 0x5A5A5A5A to address 2 in cycle N and read address 2 in cycle N+1. Expect 0x5A5A5A5A in cycle N+3.

Source files
------------

// File: rtl/sram_requester_pkg.sv
// ============================================================
// Module : sram_requester_pkg
// Brief  : shared defaults and state type for the SRAM requester
// Rev    : 1.0
// ============================================================
`default_nettype none

package sram_requester_pkg;

    localparam int C_ADDR_W_DEF     = 10;
    localparam int C_DATA_W_DEF     = 32;
    localparam int C_MASK_W_DEF     = 4;
    localparam int C_RESP_DEPTH_DEF = 3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } req_state_e;

endpackage

`default_nettype wire

// File: rtl/sram_resp_fifo.sv
// ============================================================
// Module : sram_resp_fifo
// Brief  : small synchronous FIFO holding read responses
// Rev    : 1.0
// ============================================================
`default_nettype none

module sram_resp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             not_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop     = pop && (r_count != '0);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign not_empty = (r_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The requester throttles acceptance so a push never lands on a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !w_pop && (r_count == C_DEPTH)));

endmodule

`default_nettype wire

// File: rtl/sram_rw_requester.sv
// ============================================================
// Module : sram_rw_requester
// Brief  : valid/ready front end driving a 1-cycle-latency RW0 SRAM
// Rev    : 1.0
// ============================================================
`default_nettype none

module sram_rw_requester
    import sram_requester_pkg::*;
#(
    parameter int ADDR_W        = C_ADDR_W_DEF,
    parameter int DATA_W        = C_DATA_W_DEF,
    parameter int MASK_W        = C_MASK_W_DEF,
    parameter int RESP_DEPTH    = C_RESP_DEPTH_DEF,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [CNT_W:0] C_RESP_DEPTH = (CNT_W + 1)'(RESP_DEPTH);

    req_state_e        r_state;
    req_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr;
    logic              r_rd_pending;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_occupancy;
    logic              w_room;
    logic              w_fire;
    logic              w_pop;

    // In-flight reads count against FIFO space so the push never overflows.
    assign w_occupancy = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_rd_pending};
    assign w_room      = (w_occupancy < C_RESP_DEPTH);
    assign w_fire      = (r_state == RUN) && w_room && req_valid;
    assign w_pop       = resp_valid && resp_ready;
    assign init_done   = (r_state == RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = (INIT_ON_RESET != 0) ? INIT : RUN;
            INIT:    w_state_nxt = (r_init_addr == '1) ? RUN : INIT;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        case (r_state)
            INIT: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = r_init_addr;
                sram_wmask = '1;
            end
            RUN: begin
                req_ready = w_room;
                if (w_fire) begin
                    sram_en    = 1'b1;
                    sram_wmode = req_write;
                    sram_addr  = req_addr;
                    sram_wmask = req_wmask;
                    sram_wdata = req_wdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_init_addr  <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_init_addr <= r_init_addr + 1'b1;
            end
            r_rd_pending <= w_fire && !req_write;
        end
    end

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .push      (r_rd_pending),
        .push_data (sram_rdata),
        .pop       (w_pop),
        .pop_data  (resp_rdata),
        .count     (w_fifo_count),
        .not_empty (resp_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_requester.sv
// ============================================================
// Module : tb_sram_rw_requester
// Brief  : randomized self-checking bench for sram_rw_requester
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_sram_rw_requester;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int RD = 3;
    localparam int NW = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [MW-1:0] req_wmask;
    logic          resp_valid, resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic          sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int last_acc_cyc = 0;
    int last_resp_cyc = 0;
    logic [DW-1:0] last_rdata = '0;
    int rsp_cyc_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] sram_mem [NW];
    bit   rand_rr = 1'b0;
    bit   prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    int   bp_w;

    sram_rw_requester #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RESP_DEPTH(RD), .INIT_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM macro model; contents are scrambled while in reset so only the zero-fill can clear them.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NW; i++) sram_mem[i] <= $urandom;
        end else if (sram_en) begin
            if (sram_wmode) begin
                for (int b = 0; b < MW; b++)
                    if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Reference model: word-array memory plus an ordered queue of expected read data.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            for (int i = 0; i < NW; i++) ref_mem[i] = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && resp_valid)
                check_eq("resp_hold", 64'(resp_rdata), 64'(prev_data));
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("resp_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("resp_data", 64'(resp_rdata), 64'(exp_q.pop_front()));
                end
                last_rdata    = resp_rdata;
                last_resp_cyc = cyc;
                rsp_cyc_q.push_back(cyc);
            end
            if (req_valid && req_ready) begin
                n_acc++;
                last_acc_cyc = cyc;
                if (req_write) begin
                    for (int b = 0; b < MW; b++)
                        if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
            prev_stall = resp_valid && !resp_ready;
            prev_data  = resp_rdata;
        end
    end

    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m, output int waits);
        int  w;
        bit  ok;
        w  = 0;
        ok = 1'b0;
        req_write = wr; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
        while (w < 200) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock); #1;
            if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
            w++;
        end
        check_eq("req_handshake", 64'(ok), 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
        waits = w;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
        @(posedge clock); #1;
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Releases reset and follows BOOT and the zero-fill; optionally re-asserts reset mid-fill.
    task automatic run_boot(input int abort_at);
        logic [43:0] e;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("boot", 64'({sram_en, init_done, req_ready}), 64'd0);
        for (int k = 0; k < NW; k++) begin
            @(negedge clock);
            e = {1'b1, 1'b1, AW'(k), 4'hF, 32'h0, 1'b0, 1'b0};
            check_eq("zf_wr", 64'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
                                   req_ready, init_done}), 64'(e));
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_eq("rst_mid_init", 64'({sram_en, req_ready, init_done, resp_valid}), 64'd0);
                return;
            end
        end
        @(negedge clock);
        check_eq("run_entry", 64'({init_done, req_ready, sram_en}), 64'b110);
        @(posedge clock); #1;
    endtask

    initial begin
        int w, ws, fa, wc, base, rbase;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("reset_outs", 64'({req_ready, resp_valid, init_done, sram_en}), 64'd0);
        run_boot(-1);

        do_req(1'b0, 4'd7, '0, '0, w);
        drain();
        check_eq("zf_read7", 64'(last_rdata), 64'd0);

        do_req(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, w);
        do_req(1'b1, 4'd3, 32'h11223344, 4'h5, w);
        do_req(1'b0, 4'd3, '0, '0, w);
        drain();
        check_eq("masked_wr", 64'(last_rdata), 64'hAA22CC44);

        for (int i = 0; i < 8; i++) do_req(1'b1, AW'(i), $urandom, 4'hF, w);

        // Backpressure: only RESP_DEPTH reads may be outstanding.
        resp_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int i = 0; i < 5; i++) do_req(1'b0, AW'(i), '0, '0, bp_w);
            end
        join_none
        repeat (10) @(posedge clock);
        @(negedge clock);
        check_eq("bp_accepts", 64'(n_acc - base), 64'd3);
        check_eq("bp_ready", 64'(req_ready), 64'd0);
        check_eq("bp_valid", 64'(resp_valid), 64'd1);
        @(posedge clock); #1;
        resp_ready = 1'b1;
        wait fork;
        drain();
        check_eq("bp_total", 64'(n_acc - base), 64'd5);

        // Throughput: back-to-back reads, responses two cycles later on consecutive cycles.
        rbase = rsp_cyc_q.size();
        ws = 0;
        fa = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b0, AW'(i), '0, '0, w);
            if (i == 0) fa = last_acc_cyc;
            ws += w;
        end
        drain();
        check_eq("tput_stalls", 64'(ws), 64'd0);
        check_eq("tput_nresp", 64'(rsp_cyc_q.size() - rbase), 64'd8);
        for (int i = 0; i < 8 && rbase + i < rsp_cyc_q.size(); i++)
            check_eq("tput_cycle", 64'(rsp_cyc_q[rbase + i]), 64'(fa + 2 + i));

        // Write then immediate read of the same address.
        do_req(1'b1, 4'd2, 32'h5A5A5A5A, 4'hF, w);
        wc = last_acc_cyc;
        do_req(1'b0, 4'd2, '0, '0, w);
        drain();
        check_eq("hazard_cycle", 64'(last_resp_cyc), 64'(wc + 3));
        check_eq("hazard_data", 64'(last_rdata), 64'h5A5A5A5A);

        // Reset in the middle of the zero-fill.
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        run_boot(9);
        repeat (2) @(posedge clock);
        run_boot(-1);

        // Reset with two responses queued.
        resp_ready = 1'b0;
        do_req(1'b0, 4'd2, '0, '0, w);
        do_req(1'b0, 4'd3, '0, '0, w);
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("queued_valid", 64'(resp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check_eq("queued_rst", 64'({resp_valid, req_ready, sram_en, init_done}), 64'd0);
        resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        run_boot(-1);
        do_req(1'b0, 4'd2, '0, '0, w);
        drain();
        check_eq("post_rst_read", 64'(last_rdata), 64'd0);

        // Random mixed traffic with random response backpressure.
        rand_rr = 1'b1;
        for (int i = 0; i < 120; i++) begin
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, NW - 1)), $urandom,
                   MW'($urandom_range(0, 15)), w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_rr = 1'b0;
        resp_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
